// File: rtl/trap_unit_if.sv
// Trap unit bus: commit-stage event inputs, CSR write port, interrupt lines,
// flush handshake and the architectural CSR images driven back by the unit.
// master = pipeline/CSR-file side, slave = the trap unit itself.
interface trap_unit_if #(
  parameter int XLEN          = 32,
  parameter int NUM_LOCAL_IRQ = 16
);
  logic [XLEN-1:0]             pc;
  logic                        commit_valid;
  logic                        exc_valid;
  logic [3:0]                  exc_code;
  logic [XLEN-1:0]             exc_tval;
  logic                        mret;
  logic                        irq_sw;
  logic                        irq_timer;
  logic                        irq_ext;
  logic [NUM_LOCAL_IRQ-1:0]    irq_local;
  logic [15+NUM_LOCAL_IRQ:0]   mie_mask;
  logic [XLEN-3:0]             mtvec_base;
  logic [1:0]                  mtvec_mode;
  logic                        csr_wr_en;
  logic [1:0]                  csr_wr_sel;
  logic [XLEN-1:0]             csr_wdata;
  logic                        trap_req;
  logic                        flush_ack;
  logic                        redirect_valid;
  logic [XLEN-1:0]             redirect_pc;
  logic                        mstatus_mie;
  logic                        mstatus_mpie;
  logic [1:0]                  mstatus_mpp;
  logic [XLEN-1:0]             mepc;
  logic [XLEN-1:0]             mcause;
  logic [XLEN-1:0]             mtval;
  logic [15+NUM_LOCAL_IRQ:0]   mip;

  modport master (
    output pc, commit_valid, exc_valid, exc_code, exc_tval, mret,
           irq_sw, irq_timer, irq_ext, irq_local, mie_mask, mtvec_base, mtvec_mode,
           csr_wr_en, csr_wr_sel, csr_wdata, flush_ack,
    input  trap_req, redirect_valid, redirect_pc, mstatus_mie, mstatus_mpie,
           mstatus_mpp, mepc, mcause, mtval, mip
  );

  modport slave (
    input  pc, commit_valid, exc_valid, exc_code, exc_tval, mret,
           irq_sw, irq_timer, irq_ext, irq_local, mie_mask, mtvec_base, mtvec_mode,
           csr_wr_en, csr_wr_sel, csr_wdata, flush_ack,
    output trap_req, redirect_valid, redirect_pc, mstatus_mie, mstatus_mpie,
           mstatus_mpp, mepc, mcause, mtval, mip
  );
endinterface

// File: rtl/trap_unit.sv
// Machine-mode trap/MRET sequencer: latches a commit-stage event, flushes, then redirects fetch.
// Latency: event in cycle N -> trap_req from N+1; flush_ack at M -> redirect pulse + CSR update at M+1.
// Backpressure: trap_req held until flush_ack; new events wait in IDLE. Macro TRAP_UNIT_VECTORED_EN enables vectored interrupts.
module trap_unit #(
  parameter int XLEN          = 32,
  parameter int NUM_LOCAL_IRQ = 16
) (
  input logic        clk,
  input logic        rst,
  trap_unit_if.slave bus
);

  localparam int NIRQ = 16 + NUM_LOCAL_IRQ;

  typedef enum logic [1:0] {IDLE, REQ, REDIRECT} state_t;
  typedef enum logic [1:0] {KIND_EXC, KIND_IRQ, KIND_MRET} kind_t;

  state_t          state, next_state;
  kind_t           kind_q;
  logic [4:0]      cause_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] tval_q;

  logic            mie_q, mpie_q;
  logic [XLEN-1:0] mepc_q, mcause_q, mtval_q, redirect_pc_q;
  logic [NIRQ-1:0] mip_q, mip_d;

  logic [NIRQ-1:0] pending;
  logic [4:0]      irq_cause;
  logic            irq_any, irq_take, event_take;
  logic            trap_req, redirect_valid;
  logic            vec_en;
  logic [XLEN-1:0] trap_base, trap_target;

  // Raw interrupt lines mapped onto their mip bit positions.
  always_comb begin
    mip_d = '0;
    mip_d[3]  = bus.irq_sw;
    mip_d[7]  = bus.irq_timer;
    mip_d[11] = bus.irq_ext;
    mip_d[NIRQ-1:16] = bus.irq_local;
  end

  // Pending register: sampled every cycle, no gating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mip_q <= '0;
    else     mip_q <= mip_d;
  end

  assign pending = mip_q & bus.mie_mask;
  assign irq_any = pending[11] | pending[3] | pending[7] | (|pending[NIRQ-1:16]);

  // Only the architected bit positions can ever be set in mip.
  logic unused_pending;
  assign unused_pending = ^{pending[15:12], pending[10:8], pending[6:4], pending[2:0]};

  // Interrupt arbitration: later assignments win, so lowest priority is written first.
  always_comb begin
    irq_cause = '0;
    for (int i = 0; i < NUM_LOCAL_IRQ; i++) begin
      if (pending[16+i]) irq_cause = 5'(16 + i);
    end
    if (pending[7])  irq_cause = 5'd7;
    if (pending[3])  irq_cause = 5'd3;
    if (pending[11]) irq_cause = 5'd11;
  end

  assign irq_take   = bus.commit_valid && mie_q && irq_any;
  assign event_take = (state == IDLE) && (bus.exc_valid || irq_take || bus.mret);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state and handshake outputs.
  always_comb begin
    next_state     = state;
    trap_req       = 1'b0;
    redirect_valid = 1'b0;
    case (state)
      IDLE: begin
        if (bus.exc_valid || irq_take || bus.mret) next_state = REQ;
      end
      REQ: begin
        trap_req = 1'b1;
        if (bus.flush_ack) next_state = REDIRECT;
      end
      REDIRECT: begin
        redirect_valid = 1'b1;
        next_state     = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Event capture: everything needed later is frozen here so input changes during REQ are harmless.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kind_q  <= KIND_EXC;
      cause_q <= '0;
      pc_q    <= '0;
      tval_q  <= '0;
    end else if (event_take) begin
      pc_q <= bus.pc;
      if (bus.exc_valid) begin
        kind_q  <= KIND_EXC;
        cause_q <= {1'b0, bus.exc_code};
        tval_q  <= bus.exc_tval;
      end else if (irq_take) begin
        kind_q  <= KIND_IRQ;
        cause_q <= irq_cause;
        tval_q  <= '0;
      end else begin
        kind_q  <= KIND_MRET;
        cause_q <= '0;
        tval_q  <= '0;
      end
    end
  end

  assign trap_base = {bus.mtvec_base, 2'b00};

`ifdef TRAP_UNIT_VECTORED_EN
  assign vec_en = (bus.mtvec_mode == 2'b01) && (kind_q == KIND_IRQ);
`else
  logic unused_mode;
  assign unused_mode = ^bus.mtvec_mode;
  assign vec_en      = 1'b0;
`endif

  assign trap_target = vec_en ? (trap_base + (XLEN'(cause_q) << 2)) : trap_base;

  // CSR state: committed on the REQ->REDIRECT edge, software writes accepted only while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mie_q         <= 1'b0;
      mpie_q        <= 1'b0;
      mepc_q        <= '0;
      mcause_q      <= '0;
      mtval_q       <= '0;
      redirect_pc_q <= '0;
    end else if (state == REQ && bus.flush_ack) begin
      if (kind_q == KIND_MRET) begin
        mie_q         <= mpie_q;
        mpie_q        <= 1'b1;
        redirect_pc_q <= mepc_q;
      end else begin
        mepc_q        <= {pc_q[XLEN-1:2], 2'b00};
        mcause_q      <= {(kind_q == KIND_IRQ), {(XLEN-6){1'b0}}, cause_q};
        mtval_q       <= tval_q;
        mpie_q        <= mie_q;
        mie_q         <= 1'b0;
        redirect_pc_q <= trap_target;
      end
    end else if (state == IDLE && bus.csr_wr_en) begin
      case (bus.csr_wr_sel)
        2'd0: begin
          mie_q  <= bus.csr_wdata[3];
          mpie_q <= bus.csr_wdata[7];
        end
        2'd1:    mepc_q   <= {bus.csr_wdata[XLEN-1:2], 2'b00};
        2'd2:    mcause_q <= bus.csr_wdata;
        default: mtval_q  <= bus.csr_wdata;
      endcase
    end
  end

  assign bus.trap_req       = trap_req;
  assign bus.redirect_valid = redirect_valid;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.mstatus_mie    = mie_q;
  assign bus.mstatus_mpie   = mpie_q;
  assign bus.mstatus_mpp    = 2'b11;
  assign bus.mepc           = mepc_q;
  assign bus.mcause         = mcause_q;
  assign bus.mtval          = mtval_q;
  assign bus.mip            = mip_q;

endmodule

// File: tb/tb_trap_unit.sv
// Bench for trap_unit: directed events, expected redirect/CSR state queued on issue,
// a negedge monitor pops and compares on every redirect pulse.
module tb_trap_unit;
  localparam int XLEN = 32;
  localparam int NL   = 16;

`ifdef TRAP_UNIT_VECTORED_EN
  localparam bit VEC = 1'b1;
`else
  localparam bit VEC = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  trap_unit_if #(.XLEN(XLEN), .NUM_LOCAL_IRQ(NL)) bus ();

  trap_unit #(.XLEN(XLEN), .NUM_LOCAL_IRQ(NL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] rpc;
    logic [31:0] mcause;
    logic [31:0] mepc;
    logic [31:0] mtval;
    logic        mie;
    logic        mpie;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] rpc, input logic [31:0] mcause, input logic [31:0] mepc,
                      input logic [31:0] mtval, input logic mie, input logic mpie);
    exp_t e;
    e.rpc = rpc; e.mcause = mcause; e.mepc = mepc; e.mtval = mtval; e.mie = mie; e.mpie = mpie;
    sb.push_back(e);
  endtask

  // Monitor: every redirect pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && bus.redirect_valid === 1'b1) begin
      exp_t e;
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_redirect: got redirect_pc 0x%08h, expected no redirect", bus.redirect_pc);
      end else begin
        e = sb.pop_front();
        check("sb_redirect_pc", bus.redirect_pc, e.rpc);
        check("sb_mcause", bus.mcause, e.mcause);
        check("sb_mepc", bus.mepc, e.mepc);
        check("sb_mtval", bus.mtval, e.mtval);
        check("sb_mie", {31'b0, bus.mstatus_mie}, {31'b0, e.mie});
        check("sb_mpie", {31'b0, bus.mstatus_mpie}, {31'b0, e.mpie});
        check("sb_mpp", {30'b0, bus.mstatus_mpp}, 32'd3);
      end
    end
  end

  task automatic clear_events();
    bus.pc = '0; bus.commit_valid = 1'b0; bus.exc_valid = 1'b0; bus.exc_code = '0;
    bus.exc_tval = '0; bus.mret = 1'b0; bus.csr_wr_en = 1'b0; bus.csr_wr_sel = '0;
    bus.csr_wdata = '0; bus.flush_ack = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_write(input logic [1:0] sel, input logic [31:0] data);
    step();
    bus.csr_wr_en = 1'b1; bus.csr_wr_sel = sel; bus.csr_wdata = data;
    step();
    bus.csr_wr_en = 1'b0;
  endtask

  task automatic wait_trap(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.trap_req === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL %s: got no trap_req within 20 cycles, expected trap_req=1", name);
    end
  endtask

  task automatic ack(input string name);
    step();
    bus.flush_ack = 1'b1;
    step();
    bus.flush_ack = 1'b0;
    @(negedge clk);
    check({name, "_redirect_pulse"}, {31'b0, bus.redirect_valid}, 32'd1);
    check({name, "_trap_req_drop"}, {31'b0, bus.trap_req}, 32'd0);
    @(negedge clk);
    check({name, "_redirect_one_cycle"}, {31'b0, bus.redirect_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    clear_events();
    bus.irq_sw = 1'b0; bus.irq_timer = 1'b1; bus.irq_ext = 1'b0; bus.irq_local = '0;
    bus.mie_mask = '0; bus.mtvec_base = 30'h20; bus.mtvec_mode = 2'b01;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_trap_req", {31'b0, bus.trap_req}, 32'd0);
    check("rst_redirect_valid", {31'b0, bus.redirect_valid}, 32'd0);
    check("rst_redirect_pc", bus.redirect_pc, 32'd0);
    check("rst_mie", {31'b0, bus.mstatus_mie}, 32'd0);
    check("rst_mpie", {31'b0, bus.mstatus_mpie}, 32'd0);
    check("rst_mpp", {30'b0, bus.mstatus_mpp}, 32'd3);
    check("rst_mepc", bus.mepc, 32'd0);
    check("rst_mcause", bus.mcause, 32'd0);
    check("rst_mtval", bus.mtval, 32'd0);
    check("rst_mip", bus.mip, 32'd0);
    step();
    bus.irq_timer = 1'b0;
    rst = 1'b0;

    // Exception with interrupts globally disabled.
    step();
    bus.exc_valid = 1'b1; bus.exc_code = 4'd2; bus.exc_tval = 32'hDEAD;
    bus.pc = 32'h104; bus.commit_valid = 1'b1;
    push(32'h80, 32'h2, 32'h104, 32'hDEAD, 1'b0, 1'b0);
    step();
    clear_events();
    @(negedge clk);
    check("exc_trap_req_next_cycle", {31'b0, bus.trap_req}, 32'd1);
    repeat (2) @(negedge clk);
    check("exc_trap_req_held", {31'b0, bus.trap_req}, 32'd1);
    ack("exc");

    // Timer interrupt; deassert and attempt a CSR write while in REQ.
    csr_write(2'd0, 32'h8);
    @(negedge clk);
    check("mstatus_write_mie", {31'b0, bus.mstatus_mie}, 32'd1);
    check("mstatus_write_mpie", {31'b0, bus.mstatus_mpie}, 32'd0);
    step();
    bus.mie_mask = 32'h80; bus.irq_timer = 1'b1; bus.commit_valid = 1'b1; bus.pc = 32'h207;
    push(VEC ? 32'h9C : 32'h80, 32'h80000007, 32'h204, 32'h0, 1'b0, 1'b1);
    wait_trap("timer_trap_req");
    step();
    bus.irq_timer = 1'b0;
    bus.csr_wr_en = 1'b1; bus.csr_wr_sel = 2'd2; bus.csr_wdata = 32'h55;
    step();
    bus.csr_wr_en = 1'b0;
    repeat (2) @(negedge clk);
    check("timer_req_survives_deassert", {31'b0, bus.trap_req}, 32'd1);
    ack("timer");
    clear_events();

    // MRET back to a software-written mepc.
    csr_write(2'd1, 32'h202);
    @(negedge clk);
    check("mepc_write_aligned", bus.mepc, 32'h200);
    step();
    bus.mret = 1'b1; bus.commit_valid = 1'b1;
    push(32'h200, 32'h80000007, 32'h200, 32'h0, 1'b1, 1'b1);
    step();
    clear_events();
    wait_trap("mret_trap_req");
    ack("mret");

    // Exception, external interrupt and MRET in one cycle: exception wins.
    step();
    bus.mie_mask = '0; bus.irq_ext = 1'b1;
    step();
    bus.mie_mask = 32'h800; bus.exc_valid = 1'b1; bus.exc_code = 4'd5; bus.exc_tval = 32'h1234;
    bus.pc = 32'h300; bus.mret = 1'b1; bus.commit_valid = 1'b1;
    push(32'h80, 32'h5, 32'h300, 32'h1234, 1'b0, 1'b1);
    step();
    clear_events();
    bus.irq_ext = 1'b0; bus.mie_mask = '0;
    wait_trap("collide_trap_req");
    ack("collide");

    // Software over local interrupts, then highest local index wins.
    csr_write(2'd0, 32'h88);
    step();
    bus.irq_sw = 1'b1; bus.irq_local = 16'h0024; bus.mie_mask = 32'h0024_0008;
    bus.commit_valid = 1'b1; bus.pc = 32'h400;
    push(VEC ? 32'h8C : 32'h80, 32'h80000003, 32'h400, 32'h0, 1'b0, 1'b1);
    wait_trap("sw_trap_req");
    check("mip_pattern", bus.mip, 32'h0024_0008);
    step();
    bus.irq_sw = 1'b0;
    ack("sw");
    push(VEC ? 32'hD4 : 32'h80, 32'h80000015, 32'h400, 32'h0, 1'b0, 1'b1);
    csr_write(2'd0, 32'h8);
    wait_trap("local_trap_req");
    step();
    bus.irq_local = '0; bus.mie_mask = '0;
    ack("local");
    clear_events();

    // Stray flush_ack while idle.
    step();
    bus.flush_ack = 1'b1;
    step();
    bus.flush_ack = 1'b0;
    @(negedge clk);
    check("idle_ack_trap_req", {31'b0, bus.trap_req}, 32'd0);
    check("idle_ack_redirect", {31'b0, bus.redirect_valid}, 32'd0);

    // Reset in the middle of a pending trap.
    step();
    bus.exc_valid = 1'b1; bus.exc_code = 4'd1; bus.exc_tval = 32'h77;
    bus.pc = 32'h500; bus.commit_valid = 1'b1;
    step();
    clear_events();
    @(negedge clk);
    check("pre_rst_trap_req", {31'b0, bus.trap_req}, 32'd1);
    step();
    rst = 1'b1;
    #1;
    check("rst_mid_trap_req", {31'b0, bus.trap_req}, 32'd0);
    check("rst_mid_mepc", bus.mepc, 32'd0);
    check("rst_mid_mcause", bus.mcause, 32'd0);
    check("rst_mid_mtval", bus.mtval, 32'd0);
    check("rst_mid_redirect_pc", bus.redirect_pc, 32'd0);
    step();
    rst = 1'b0;
    bus.flush_ack = 1'b1;
    step();
    bus.flush_ack = 1'b0;
    @(negedge clk);
    check("late_ack_trap_req", {31'b0, bus.trap_req}, 32'd0);
    check("late_ack_redirect", {31'b0, bus.redirect_valid}, 32'd0);

    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
